graduation_list: RTL

In-order completion tracker (graduation list) that gives every decoded instruction a tag ID, gathers result data from a parametrised number of writeback ports, and retires instructions to the register file strictly in program order. It sits between decode and register-file writeback. It generalises the decoded-instruction record by adding instruction IDs, configurable depth and configurable writeback-port count, plus completion tracking, in-order retirement and flush.

---
 rtl/graduation_list.sv | 109 ++++++++++
 1 files changed

// File: rtl/graduation_list.sv
// In-order completion tracker: tags decoded instructions, collects
// results from several writeback ports and retires them in program order.
module graduation_list #(
   parameter int ARCH_LEN = 32,
   parameter int REG_FILE_LEN = 32,
   parameter int DEPTH = 8,
   parameter int NUM_WB = 2,
   localparam int RW = $clog2(REG_FILE_LEN),
   localparam int IDW = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   input  logic                     alloc_valid_i,
   output logic                     alloc_ready_o,
   input  logic [RW-1:0]            alloc_dst_reg_i,
   input  logic                     alloc_reg_write_enable_i,
   input  logic                     alloc_is_store_i,
   output logic [IDW-1:0]           alloc_id_o,
   input  logic [NUM_WB-1:0]        wb_valid_i,
   input  logic [NUM_WB*IDW-1:0]    wb_id_i,
   input  logic [NUM_WB*ARCH_LEN-1:0] wb_data_i,
   output logic                     retire_valid_o,
   input  logic                     retire_ready_i,
   output logic [IDW-1:0]           retire_id_o,
   output logic [RW-1:0]            retire_dst_reg_o,
   output logic [ARCH_LEN-1:0]      retire_data_o,
   output logic                     retire_reg_write_enable_o,
   output logic                     retire_is_store_o,
   output logic [IDW:0]             count_o,
   output logic                     empty_o,
   output logic                     full_o
);

   localparam logic [IDW:0] FULL_CNT = (IDW+1)'(DEPTH);

   logic [DEPTH-1:0]    valid;
   logic [DEPTH-1:0]    done;
   logic [DEPTH-1:0]    rwe;
   logic [DEPTH-1:0]    st;
   logic [RW-1:0]       dst [DEPTH];
   logic [ARCH_LEN-1:0] data [DEPTH];
   logic [IDW-1:0]      head;
   logic [IDW-1:0]      tail;
   logic [IDW:0]        count;
   logic                alloc_fire;
   logic                retire_fire;
   logic [IDW-1:0]      wid [NUM_WB];
   logic [ARCH_LEN-1:0] wdat [NUM_WB];

   for (genvar k = 0; k < NUM_WB; k++) begin : g_wb
      assign wid[k] = wb_id_i[k*IDW +: IDW];
      assign wdat[k] = wb_data_i[k*ARCH_LEN +: ARCH_LEN];
   end

   assign full_o = (count == FULL_CNT);
   assign empty_o = (count == '0);
   assign alloc_ready_o = !full_o;
   assign alloc_id_o = tail;
   assign count_o = count;

   // Retire is decoded from registered state only; no writeback bypass.
   assign retire_valid_o = valid[head] && done[head];
   assign retire_id_o = head;
   assign retire_dst_reg_o = dst[head];
   assign retire_data_o = data[head];
   assign retire_reg_write_enable_o = rwe[head];
   assign retire_is_store_o = st[head];

   assign alloc_fire = alloc_valid_i && !full_o;
   assign retire_fire = retire_valid_o && retire_ready_i;

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         valid <= '0;
         done <= '0;
         head <= '0;
         tail <= '0;
         count <= '0;
      end else begin
         // Descending order: the lowest-index port's write lands last.
         for (int k = NUM_WB-1; k >= 0; k--) begin
            if (wb_valid_i[k] && valid[wid[k]] && !done[wid[k]]) begin
               done[wid[k]] <= 1'b1;
               data[wid[k]] <= wdat[k];
            end
         end
         if (retire_fire) begin
            valid[head] <= 1'b0;
            head <= head + 1'b1;
         end
         if (alloc_fire) begin
            valid[tail] <= 1'b1;
            done[tail] <= 1'b0;
            data[tail] <= '0;
            dst[tail] <= alloc_dst_reg_i;
            rwe[tail] <= alloc_reg_write_enable_i;
            st[tail] <= alloc_is_store_i;
            tail <= tail + 1'b1;
         end
         unique case ({alloc_fire, retire_fire})
            2'b10: count <= count + 1'b1;
            2'b01: count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
